accelbrot_com_block2word: RTL and testbench

ACCELBROT_COM_BLOCK2WORD -- requirements
Module: accelbrot_com_block2word

---
 rtl/accelbrot_com_block2word.sv | 125 ++++++++++++
 tb/tb_accelbrot_com_block2word.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/accelbrot_com_block2word.sv
// rtl/accelbrot_com_block2word.sv - block-to-word serialiser, LSB word first.
// Optional holding register for gapless back-to-back blocks: ACCELBROT_COM_B2W_PREFETCH_EN.
module accelbrot_com_block2word #(
    parameter int NWORDS = 8,
    parameter int WWIDTH = 34
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NWORDS*WWIDTH-1:0] in,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WWIDTH-1:0]        out,
    output logic                     out_start,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int BW = NWORDS * WWIDTH;
    localparam int CW = $clog2(NWORDS);
    localparam logic [CW-1:0] CNT_PRELAST = CW'(NWORDS - 2);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        SEND  = 2'd1,
        LAST  = 2'd2
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [BW-1:0] sr;
    logic          acc;
    logic          xfer;
    logic          pend;
    logic [BW-1:0] pend_data;

    assign acc  = in_valid & in_ready;
    assign xfer = out_valid & out_ready;
    // The shift register's low word is the presented word; it is zero whenever idle.
    assign out  = sr[WWIDTH-1:0];

`ifdef ACCELBROT_COM_B2W_PREFETCH_EN
    logic [BW-1:0] hold;
    logic          hold_full;

    assign in_ready  = rstn & ~hold_full;
    assign pend      = hold_full;
    assign pend_data = hold;

    // Blocks arriving while busy park here, unless the last word leaves on the same edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (acc && state != EMPTY && !(state == LAST && xfer)) begin
            hold      <= in;
            hold_full <= 1'b1;
        end else if (state == LAST && xfer) begin
            hold_full <= 1'b0;
        end
    end
`else
    assign in_ready  = rstn & ((state == EMPTY) | ((state == LAST) & out_ready));
    assign pend      = 1'b0;
    assign pend_data = '0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= EMPTY;
            cnt       <= '0;
            sr        <= '0;
            out_valid <= 1'b0;
            out_start <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc) begin
                        sr        <= in;
                        cnt       <= '0;
                        out_valid <= 1'b1;
                        out_start <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        sr        <= sr >> WWIDTH;
                        cnt       <= cnt + 1'b1;
                        out_start <= 1'b0;
                        if (cnt == CNT_PRELAST) begin
                            state <= LAST;
                        end
                    end
                end
                LAST: begin
                    if (xfer) begin
                        cnt <= '0;
                        if (pend) begin
                            sr        <= pend_data;
                            out_start <= 1'b1;
                            state     <= SEND;
                        end else if (acc) begin
                            sr        <= in;
                            out_start <= 1'b1;
                            state     <= SEND;
                        end else begin
                            sr        <= '0;
                            out_valid <= 1'b0;
                            out_start <= 1'b0;
                            state     <= EMPTY;
                        end
                    end
                end
                default: begin
                    state     <= EMPTY;
                    cnt       <= '0;
                    sr        <= '0;
                    out_valid <= 1'b0;
                    out_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accelbrot_com_block2word.sv
// tb/tb_accelbrot_com_block2word.sv - randomized scoreboard bench for accelbrot_com_block2word.
module tb_accelbrot_com_block2word;

    localparam int N  = 8;
    localparam int W  = 34;
    localparam int NB = N * W;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [NB-1:0] in = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  out;
    logic          out_start;
    logic          out_valid;
    logic          out_ready = 1'b0;

    logic [1:0]    in_b = '0;
    logic          in_valid_b = 1'b0;
    logic          in_ready_b;
    logic [0:0]    out_b;
    logic          out_start_b;
    logic          out_valid_b;
    logic          out_ready_b = 1'b0;

    int ncmp = 0;
    int nfail = 0;

    typedef struct {
        logic [W-1:0] w;
        bit           s;
    } ent_t;
    ent_t q[$];
    bit   last_acc;

    accelbrot_com_block2word #(.NWORDS(N), .WWIDTH(W)) dut (
        .clk(clk), .rstn(rstn), .in(in), .in_valid(in_valid), .in_ready(in_ready),
        .out(out), .out_start(out_start), .out_valid(out_valid), .out_ready(out_ready)
    );

    accelbrot_com_block2word #(.NWORDS(2), .WWIDTH(1)) dut_b (
        .clk(clk), .rstn(rstn), .in(in_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .out(out_b), .out_start(out_start_b), .out_valid(out_valid_b), .out_ready(out_ready_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB-1:0] rand_block();
        logic [NB-1:0] b;
        for (int k = 0; k < N; k++) b[k*W +: W] = W'({$urandom, $urandom});
        return b;
    endfunction

    // Words accepted but not yet transferred decide every expected output.
    function automatic bit exp_ready_f();
`ifdef ACCELBROT_COM_B2W_PREFETCH_EN
        return q.size() <= N;
`else
        return (q.size() == 0) || (q.size() == 1 && out_ready);
`endif
    endfunction

    task automatic step();
        bit            exp_rdy;
        bit            acc;
        bit            xf;
        logic [NB-1:0] cap;
        @(negedge clk);
        exp_rdy = exp_ready_f();
        chk("out_valid", out_valid, q.size() > 0);
        chk("out", out, q.size() > 0 ? q[0].w : '0);
        chk("out_start", out_start, q.size() > 0 ? q[0].s : 1'b0);
        chk("in_ready", in_ready, exp_rdy);
        acc = in_valid && exp_rdy;
        xf  = (q.size() > 0) && out_ready;
        cap = in;
        @(posedge clk);
        if (xf) void'(q.pop_front());
        if (acc) begin
            for (int k = 0; k < N; k++) q.push_back('{w: cap[k*W +: W], s: (k == 0)});
        end
        last_acc = acc;
        #1;
    endtask

    logic [NB-1:0] blks[3];
    logic [1:0]    blk_b[2];
    logic [0:0]    got_w[$];
    bit            got_s[$];
    int            bi;
    bit            acc_b;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out, 0);
        chk("rst_out_start", out_start, 0);
        chk("rst_in_ready", in_ready, 0);
        rstn = 1'b1;
        step();

        // Single block, word k = k+1, no backpressure
        for (int k = 0; k < N; k++) in[k*W +: W] = W'(k + 1);
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        in = rand_block();
        repeat (11) step();

        // Stalls with out_ready pattern 1,0,0,1
        in = rand_block();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            step();
        end
        out_ready = 1'b1;
        repeat (4) step();

        // Continuous in_valid with three distinct blocks
        for (int b = 0; b < 3; b++) blks[b] = rand_block();
        bi = 0;
        in = blks[0];
        in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (last_acc) begin
                bi++;
                if (bi < 3) in = blks[bi];
                else in_valid = 1'b0;
            end
        end
        chk("three_blocks_accepted", bi, 3);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            if (!in_valid || last_acc) begin
                in = rand_block();
                in_valid = ($urandom_range(0, 2) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (30) step();

        // Asynchronous reset mid-cycle while word 4 is presented
        in = rand_block();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        chk("pre_rst_word4", out, in[4*W +: W]);
        #3 rstn = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out", out, 0);
        chk("arst_out_start", out_start, 0);
        chk("arst_in_ready", in_ready, 0);
        q.delete();
        @(posedge clk);
        #3 rstn = 1'b1;
        repeat (3) step();
        in = rand_block();
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (10) step();

        // Two-word one-bit instance, blocks 2'b10 then 2'b01
        blk_b[0] = 2'b10;
        blk_b[1] = 2'b01;
        bi = 0;
        in_b = blk_b[0];
        in_valid_b = 1'b1;
        out_ready_b = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid_b) begin
                got_w.push_back(out_b);
                got_s.push_back(out_start_b);
            end
            acc_b = in_valid_b && in_ready_b;
            @(posedge clk);
            #1;
            if (acc_b) begin
                bi++;
                if (bi < 2) in_b = blk_b[bi];
                else in_valid_b = 1'b0;
            end
        end
        chk("b_word_count", got_w.size(), 4);
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 2; k++) begin
                if (got_w.size() > b * 2 + k) begin
                    chk("b_word", got_w[b*2+k], blk_b[b][k]);
                    chk("b_start", got_s[b*2+k], k == 0);
                end
            end
        end
        chk("b_idle_valid", out_valid_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
